atx_pll_reconfig_ctrl: RTL and testbench
========================================

Name: atx_pll_reconfig_ctrl

Overview:
Sequences dynamic reconfiguration of one Stratix 10 H-tile ATX PLL through its reconfig AVMM port. A host posts single commands: an optional read-modify-write of one PLL register, optionally followed by recalibration and a wait for lock. The block drives the reconfig_*0 AVMM signals, monitors pll_cal_busy and pll_locked, and returns one status response per command. It sits between the system CSR/Nios master and the ATX PLL instance.

Parameters:
CAL_ADDR, 11'h100, PLL register that triggers recalibration
CAL_MASK, 32'h0000_0002, bits of CAL_ADDR written to start calibration
TIMEOUT_CYC, 1000000, maximum cycles allowed for each wait phase (cal start, cal end, lock)
CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
reconfig_clk  in  1  only clock; shared with the PLL reconfig_clk0
reconfig_reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_addr  in  11  target PLL register
cmd_mask  in  32  bits to modify; 0 means no RMW (read only)
cmd_data  in  32  new values for masked bits
cmd_recal  in  1  run calibration and lock wait after the RMW
rsp_valid  out  1  one-cycle response strobe
rsp_status  out  2  0=OK, 1=CAL_TIMEOUT, 2=LOCK_TIMEOUT
rsp_rdata  out  32  value read from cmd_addr before modification
avmm_write  out  1  to reconfig_write0
avmm_read  out  1  to reconfig_read0
avmm_address  out  11  to reconfig_address0
avmm_writedata  out  32  to reconfig_writedata0
avmm_readdata  in  32  from reconfig_readdata0
avmm_waitrequest  in  1  from reconfig_waitrequest0
pll_cal_busy  in  1  from the PLL
pll_locked  in  1  from the PLL
busy  out  1  high whenever the FSM is outside IDLE

Behaviour:
- Reset: state IDLE; cmd_ready=1; rsp_valid=0; rsp_status=0; rsp_rdata=0; avmm_read, avmm_write, avmm_address and avmm_writedata = 0; busy=0; timeout counter = 0.
- Input sync: pll_cal_busy and pll_locked each pass through a 2-flop synchronizer. All decisions use the synchronized values.
- AVMM rules:
  - read/write, address and writedata are held stable until the first cycle with waitrequest=0; that cycle completes the transfer.
  - readdata is captured in the completing cycle of the read.
  - read and write are never asserted together.
- States:
  - IDLE: cmd_ready=1. On valid&ready, latch addr, mask, data and recal, go to RD. cmd_ready=0 in every other state.
  - RD: read cmd_addr, capture rdata. If mask!=0 go to WR; else if recal go to CAL_RD; else go to DONE.
  - WR: write (rdata & ~mask) | (data & mask). Then go to CAL_RD if recal, else DONE.
  - CAL_RD: read CAL_ADDR into a scratch register.
  - CAL_WR: write scratch | CAL_MASK. Clear the timeout counter.
  - WAIT_BUSY_HI: wait for cal_busy=1.
  - WAIT_BUSY_LO: wait for cal_busy=0.
  - WAIT_LOCK: wait for locked=1.
  - The three wait states clear the timeout counter on entry. If the counter reaches TIMEOUT_CYC-1 with no exit condition, go to DONE with status CAL_TIMEOUT (busy waits) or LOCK_TIMEOUT (lock wait).
  - DONE: rsp_valid=1 for exactly one cycle with rsp_rdata=rdata and rsp_status; next state IDLE.
- Latency, single command, waitrequest=0, mask!=0, no recal: accept at cycle 0; RD asserted at 1; WR at 2; rsp_valid at 3; cmd_ready=1 again at 4.
- Boundary cases:
  - cal_busy already high when entering WAIT_BUSY_HI: that state exits on its first cycle.
  - Lock arriving in the same cycle as the timeout: lock wins and status is OK.
  - cmd_valid while busy: ignored; the host holds it until ready.
  - Reset mid-transfer: AVMM strobes drop in the next cycle and any pending transfer is abandoned.
  - mask=0 with recal=0: pure read, no write issued.
- Counter saturates; it never wraps.

Decomposition:
- Package atx_pll_reconfig_pkg holds:
  - the state enum;
  - status encodings ST_OK, ST_CAL_TO, ST_LOCK_TO;
  - default CAL_ADDR and CAL_MASK constants.
- Sub-module: atx_pll_avmm_xfer, a single-transfer AVMM engine. Interface: start, rnw, addr, wdata → done, rdata. It holds the strobes until waitrequest is low and is reused by RD, WR, CAL_RD and CAL_WR.

Test Plan:
- RMW, no wait states: addr=0x010, readdata=0xAAAA_5555, mask=0x0000_FF00, data=0x1234_3400 → one write of 0xAAAA_3455; rsp_rdata=0xAAAA_5555; status 0; rsp_valid at cycle 3.
- Waitrequest stretch: waitrequest held high for 5 cycles on read and on write → strobes, address and data remain stable throughout; exactly one read and one write complete.
- Recal happy path, CAL_ADDR readdata=0x0: write of 0x0000_0002 to 0x100; cal_busy high 10 cycles, then low; locked rises 20 cycles later → status 0; busy falls after DONE.
- Cal timeout, TIMEOUT_CYC=50: cal_busy never rises → rsp_status=1 exactly 50 cycles after WAIT_BUSY_HI entry; no further AVMM traffic.
- Lock timeout plus simultaneity: lock never asserts → status 2. Rerun with locked rising in the final counter cycle → status 0.
- Reset mid-write, with waitrequest stuck high: assert reconfig_reset for 1 cycle → next cycle write=0, cmd_ready=1, no rsp_valid; the next command executes normally.

Source files
------------

// File: rtl/atx_pll_reconfig_pkg.sv
// Shared types and defaults for the ATX PLL reconfiguration controller.
package atx_pll_reconfig_pkg;

    localparam logic [10:0] DEF_CAL_ADDR = 11'h100;
    localparam logic [31:0] DEF_CAL_MASK = 32'h0000_0002;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_CAL_RD,
        S_CAL_WR,
        S_WAIT_BUSY_HI,
        S_WAIT_BUSY_LO,
        S_WAIT_LOCK,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_CAL_TO  = 2'd1,
        ST_LOCK_TO = 2'd2
    } status_e;

    function automatic logic [31:0] rmw_merge(input logic [31:0] old_val,
                                              input logic [31:0] mask,
                                              input logic [31:0] new_val);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/atx_pll_reconfig_if.sv
// Host command/response, PLL reconfig AVMM and PLL status signals of the controller.
interface atx_pll_reconfig_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_addr;
    logic [31:0] cmd_mask;
    logic [31:0] cmd_data;
    logic        cmd_recal;
    logic        rsp_valid;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_rdata;
    logic        avmm_write;
    logic        avmm_read;
    logic [10:0] avmm_address;
    logic [31:0] avmm_writedata;
    logic [31:0] avmm_readdata;
    logic        avmm_waitrequest;
    logic        pll_cal_busy;
    logic        pll_locked;
    logic        busy;

    // Controller side: masters the AVMM port, serves host commands.
    modport master (
        input  cmd_valid, cmd_addr, cmd_mask, cmd_data, cmd_recal,
        input  avmm_readdata, avmm_waitrequest, pll_cal_busy, pll_locked,
        output cmd_ready, rsp_valid, rsp_status, rsp_rdata,
        output avmm_write, avmm_read, avmm_address, avmm_writedata, busy
    );

    // Environment side: host plus PLL reconfig slave.
    modport slave (
        output cmd_valid, cmd_addr, cmd_mask, cmd_data, cmd_recal,
        output avmm_readdata, avmm_waitrequest, pll_cal_busy, pll_locked,
        input  cmd_ready, rsp_valid, rsp_status, rsp_rdata,
        input  avmm_write, avmm_read, avmm_address, avmm_writedata, busy
    );

endinterface

// File: rtl/atx_pll_avmm_xfer.sv
// Single-transfer AVMM engine: registers one read or write and holds it until waitrequest drops.
module atx_pll_avmm_xfer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        rnw_i,
    input  logic [10:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        avmm_read_o,
    output logic        avmm_write_o,
    output logic [10:0] avmm_address_o,
    output logic [31:0] avmm_writedata_o,
    input  logic [31:0] avmm_readdata_i,
    input  logic        avmm_waitrequest_i
);

    logic        read_q;
    logic        write_q;
    logic [10:0] addr_q;
    logic [31:0] wdata_q;

    // start wins over completion so a follow-on transfer issues with no idle cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start_i) begin
            read_q  <= rnw_i;
            write_q <= ~rnw_i;
            addr_q  <= addr_i;
            wdata_q <= rnw_i ? wdata_q : wdata_i;
        end else if (done_o) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end
    end

    assign done_o           = (read_q | write_q) & ~avmm_waitrequest_i;
    assign rdata_o          = avmm_readdata_i;
    assign avmm_read_o      = read_q;
    assign avmm_write_o     = write_q;
    assign avmm_address_o   = addr_q;
    assign avmm_writedata_o = wdata_q;

endmodule

// File: rtl/atx_pll_reconfig_ctrl.sv
// Sequences one ATX PLL register RMW, optional recalibration and lock wait per host command.
module atx_pll_reconfig_ctrl
    import atx_pll_reconfig_pkg::*;
#(
    parameter logic [10:0] CAL_ADDR    = DEF_CAL_ADDR,
    parameter logic [31:0] CAL_MASK    = DEF_CAL_MASK,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic               reconfig_clk,
    input  logic               reconfig_reset,
    atx_pll_reconfig_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    status_e          status_q, status_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [10:0]      addr_q;
    logic [31:0]      mask_q, data_q;
    logic             recal_q;
    logic [31:0]      rdata_q, rdata_d, rsp_rdata_q;
    logic             cmd_ready_q, rsp_valid_q, busy_q;
    logic [1:0]       cal_sync_q, lock_sync_q;
    logic             cal_busy_s, locked_s, accept;

    logic             xfer_start, xfer_rnw, xfer_done;
    logic [10:0]      xfer_addr;
    logic [31:0]      xfer_wdata, xfer_rdata;

    assign cal_busy_s = cal_sync_q[1];
    assign locked_s   = lock_sync_q[1];
    assign accept     = bus.cmd_valid & cmd_ready_q;
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Next transfer is launched on the edge that completes the previous one.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        rdata_d    = rdata_q;
        cnt_d      = '0;
        xfer_start = 1'b0;
        xfer_rnw   = 1'b1;
        xfer_addr  = addr_q;
        xfer_wdata = '0;
        unique case (state_q)
            S_IDLE: if (accept) begin
                state_d    = S_RD;
                xfer_start = 1'b1;
                xfer_addr  = bus.cmd_addr;
            end
            S_RD: if (xfer_done) begin
                rdata_d = xfer_rdata;
                if (mask_q != '0) begin
                    state_d    = S_WR;
                    xfer_start = 1'b1;
                    xfer_rnw   = 1'b0;
                    xfer_wdata = rmw_merge(xfer_rdata, mask_q, data_q);
                end else if (recal_q) begin
                    state_d    = S_CAL_RD;
                    xfer_start = 1'b1;
                    xfer_addr  = CAL_ADDR;
                end else begin
                    state_d  = S_DONE;
                    status_d = ST_OK;
                end
            end
            S_WR: if (xfer_done) begin
                if (recal_q) begin
                    state_d    = S_CAL_RD;
                    xfer_start = 1'b1;
                    xfer_addr  = CAL_ADDR;
                end else begin
                    state_d  = S_DONE;
                    status_d = ST_OK;
                end
            end
            S_CAL_RD: if (xfer_done) begin
                state_d    = S_CAL_WR;
                xfer_start = 1'b1;
                xfer_rnw   = 1'b0;
                xfer_addr  = CAL_ADDR;
                xfer_wdata = xfer_rdata | CAL_MASK;
            end
            S_CAL_WR: if (xfer_done) state_d = S_WAIT_BUSY_HI;
            S_WAIT_BUSY_HI: begin
                if (cal_busy_s) state_d = S_WAIT_BUSY_LO;
                else if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    status_d = ST_CAL_TO;
                end else cnt_d = cnt_inc;
            end
            S_WAIT_BUSY_LO: begin
                if (!cal_busy_s) state_d = S_WAIT_LOCK;
                else if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    status_d = ST_CAL_TO;
                end else cnt_d = cnt_inc;
            end
            // lock is tested before the timeout so a coincident lock reports OK
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d  = S_DONE;
                    status_d = ST_OK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    status_d = ST_LOCK_TO;
                end else cnt_d = cnt_inc;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge reconfig_clk) begin
        if (reconfig_reset) begin
            state_q     <= S_IDLE;
            status_q    <= ST_OK;
            cnt_q       <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            recal_q     <= 1'b0;
            rdata_q     <= '0;
            rsp_rdata_q <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cal_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            cal_sync_q  <= {cal_sync_q[0], bus.pll_cal_busy};
            lock_sync_q <= {lock_sync_q[0], bus.pll_locked};
            if (accept) begin
                addr_q  <= bus.cmd_addr;
                mask_q  <= bus.cmd_mask;
                data_q  <= bus.cmd_data;
                recal_q <= bus.cmd_recal;
            end
            cmd_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            rsp_valid_q <= (state_d == S_DONE);
            if (state_d == S_DONE) rsp_rdata_q <= rdata_d;
        end
    end

    atx_pll_avmm_xfer u_xfer (
        .clk_i              (reconfig_clk),
        .rst_i              (reconfig_reset),
        .start_i            (xfer_start),
        .rnw_i              (xfer_rnw),
        .addr_i             (xfer_addr),
        .wdata_i            (xfer_wdata),
        .done_o             (xfer_done),
        .rdata_o            (xfer_rdata),
        .avmm_read_o        (bus.avmm_read),
        .avmm_write_o       (bus.avmm_write),
        .avmm_address_o     (bus.avmm_address),
        .avmm_writedata_o   (bus.avmm_writedata),
        .avmm_readdata_i    (bus.avmm_readdata),
        .avmm_waitrequest_i (bus.avmm_waitrequest)
    );

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_status = status_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_atx_pll_reconfig_ctrl.sv
// Directed bench for atx_pll_reconfig_ctrl with an AVMM slave model and scheduled PLL status inputs.
module tb_atx_pll_reconfig_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    atx_pll_reconfig_if bus();

    atx_pll_reconfig_ctrl #(.TIMEOUT_CYC(50), .CNT_W(20)) dut (
        .reconfig_clk   (clk),
        .reconfig_reset (rst),
        .bus            (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // AVMM slave: fixed read values per address, programmable stall per transfer
    logic [31:0] user_reg = 32'h0;
    logic [31:0] cal_reg  = 32'h0;
    int          stall_rd_n = 0;
    int          stall_wr_n = 0;
    int          stall_cnt  = 0;
    int          rd_count   = 0;
    int          wr_count   = 0;
    logic [10:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    int sch_busy_on  = -1;
    int sch_busy_off = -1;
    int sch_lock_on  = -1;

    assign bus.avmm_readdata    = (bus.avmm_address == 11'h100) ? cal_reg : user_reg;
    assign bus.avmm_waitrequest = (bus.avmm_read  && stall_cnt < stall_rd_n) ||
                                  (bus.avmm_write && stall_cnt < stall_wr_n);

    always @(posedge clk) begin
        if ((bus.avmm_read || bus.avmm_write) && bus.avmm_waitrequest) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
        if (!rst && bus.avmm_read && !bus.avmm_waitrequest) rd_count <= rd_count + 1;
        if (!rst && bus.avmm_write && !bus.avmm_waitrequest) begin
            wr_count     <= wr_count + 1;
            last_wr_addr <= bus.avmm_address;
            last_wr_data <= bus.avmm_writedata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_pll();
        bus.pll_cal_busy = 1'b0;
        bus.pll_locked   = 1'b0;
        sch_busy_on  = -1;
        sch_busy_off = -1;
        sch_lock_on  = -1;
        step(4);
    endtask

    // Presents one command at the current cycle (cycle 0) and follows it until rsp_valid or limit.
    task automatic issue(input logic [10:0] a, input logic [31:0] m, input logic [31:0] d,
                         input logic rc, input int limit, output bit got, output int cyc,
                         output logic [31:0] rdata, output logic [1:0] st);
        got   = 1'b0;
        rdata = 'x;
        st    = 'x;
        bus.cmd_addr  = a;
        bus.cmd_mask  = m;
        bus.cmd_data  = d;
        bus.cmd_recal = rc;
        bus.cmd_valid = 1'b1;
        step(1);
        bus.cmd_valid = 1'b0;
        cyc = 1;
        while (cyc <= limit) begin
            if (cyc == sch_busy_on)  bus.pll_cal_busy = 1'b1;
            if (cyc == sch_busy_off) bus.pll_cal_busy = 1'b0;
            if (cyc == sch_lock_on)  bus.pll_locked   = 1'b1;
            if (bus.rsp_valid === 1'b1) begin
                got   = 1'b1;
                rdata = bus.rsp_rdata;
                st    = bus.rsp_status;
                break;
            end
            step(1);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_status !== 2'd0 || bus.rsp_rdata !== 32'h0)
            $display("FAIL reset_rsp: got valid=%b status=%0d rdata=%h want 0/0/0", bus.rsp_valid, bus.rsp_status, bus.rsp_rdata); else n_pass++;
        n_checks++; if (bus.avmm_read !== 1'b0 || bus.avmm_write !== 1'b0 || bus.avmm_address !== 11'h0 || bus.avmm_writedata !== 32'h0)
            $display("FAIL reset_avmm: got rd=%b wr=%b addr=%h wd=%h want all 0", bus.avmm_read, bus.avmm_write, bus.avmm_address, bus.avmm_writedata); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_rmw_latency();
        int rd0 = rd_count;
        int wr0 = wr_count;
        user_reg = 32'hAAAA_5555;
        bus.cmd_addr  = 11'h010;
        bus.cmd_mask  = 32'h0000_FF00;
        bus.cmd_data  = 32'h1234_3400;
        bus.cmd_recal = 1'b0;
        bus.cmd_valid = 1'b1;
        step(1);
        bus.cmd_valid = 1'b0;
        n_checks++; if ({bus.avmm_read, bus.avmm_write, bus.avmm_address, bus.cmd_ready, bus.busy} !== {2'b10, 11'h010, 2'b01})
            $display("FAIL rmw_cycle1: got rd=%b wr=%b addr=%h ready=%b busy=%b want 1 0 010 0 1",
                     bus.avmm_read, bus.avmm_write, bus.avmm_address, bus.cmd_ready, bus.busy); else n_pass++;
        step(1);
        n_checks++; if ({bus.avmm_read, bus.avmm_write, bus.avmm_address} !== {2'b01, 11'h010} || bus.avmm_writedata !== 32'hAAAA_3455)
            $display("FAIL rmw_cycle2: got rd=%b wr=%b addr=%h wd=%h want 0 1 010 aaaa3455",
                     bus.avmm_read, bus.avmm_write, bus.avmm_address, bus.avmm_writedata); else n_pass++;
        step(1);
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hAAAA_5555 || bus.rsp_status !== 2'd0)
            $display("FAIL rmw_rsp: got valid=%b rdata=%h status=%0d want 1 aaaa5555 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_status); else n_pass++;
        step(1);
        n_checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL rmw_cycle4: got ready=%b valid=%b busy=%b want 1 0 0", bus.cmd_ready, bus.rsp_valid, bus.busy); else n_pass++;
        n_checks++; if (rd_count - rd0 !== 1 || wr_count - wr0 !== 1)
            $display("FAIL rmw_xfer_count: got reads=%0d writes=%0d want 1 1", rd_count - rd0, wr_count - wr0); else n_pass++;
    endtask

    task automatic test_pure_read();
        bit got; int cyc; logic [31:0] rd; logic [1:0] st;
        int rd0 = rd_count;
        int wr0 = wr_count;
        user_reg = 32'h1357_9BDF;
        issue(11'h011, 32'h0, 32'hFFFF_FFFF, 1'b0, 20, got, cyc, rd, st);
        n_checks++; if (!got || cyc !== 2 || rd !== 32'h1357_9BDF || st !== 2'd0)
            $display("FAIL pure_read_rsp: got seen=%b cyc=%0d rdata=%h status=%0d want 1 2 13579bdf 0", got, cyc, rd, st); else n_pass++;
        step(1);
        n_checks++; if (rd_count - rd0 !== 1 || wr_count - wr0 !== 0)
            $display("FAIL pure_read_xfers: got reads=%0d writes=%0d want 1 0", rd_count - rd0, wr_count - wr0); else n_pass++;
    endtask

    task automatic test_waitrequest();
        int bad_rd = 0;
        int bad_wr = 0;
        int rd0 = rd_count;
        int wr0 = wr_count;
        user_reg   = 32'h0000_BEEF;
        stall_rd_n = 5;
        stall_wr_n = 5;
        bus.cmd_addr  = 11'h010;
        bus.cmd_mask  = 32'hFFFF_0000;
        bus.cmd_data  = 32'hDEAD_0000;
        bus.cmd_recal = 1'b0;
        bus.cmd_valid = 1'b1;
        step(1);
        bus.cmd_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 6) begin
                if (bus.avmm_read !== 1'b1 || bus.avmm_write !== 1'b0 || bus.avmm_address !== 11'h010) bad_rd++;
            end else begin
                if (bus.avmm_write !== 1'b1 || bus.avmm_read !== 1'b0 || bus.avmm_address !== 11'h010 ||
                    bus.avmm_writedata !== 32'hDEAD_BEEF) bad_wr++;
            end
            step(1);
        end
        n_checks++; if (bad_rd !== 0) $display("FAIL stretch_read_hold: got %0d unstable cycles want 0", bad_rd); else n_pass++;
        n_checks++; if (bad_wr !== 0) $display("FAIL stretch_write_hold: got %0d unstable cycles want 0", bad_wr); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0000_BEEF)
            $display("FAIL stretch_rsp: got valid=%b rdata=%h want 1 0000beef", bus.rsp_valid, bus.rsp_rdata); else n_pass++;
        n_checks++; if (rd_count - rd0 !== 1 || wr_count - wr0 !== 1 || last_wr_data !== 32'hDEAD_BEEF)
            $display("FAIL stretch_xfers: got reads=%0d writes=%0d wd=%h want 1 1 deadbeef", rd_count - rd0, wr_count - wr0, last_wr_data); else n_pass++;
        stall_rd_n = 0;
        stall_wr_n = 0;
        step(2);
    endtask

    task automatic test_recal_ok();
        bit got; int cyc; logic [31:0] rd; logic [1:0] st;
        int rd0 = rd_count;
        int wr0 = wr_count;
        user_reg = 32'h0000_0777;
        cal_reg  = 32'h0;
        sch_busy_on  = 6;
        sch_busy_off = 16;
        sch_lock_on  = 36;
        issue(11'h020, 32'h0, 32'h0, 1'b1, 100, got, cyc, rd, st);
        n_checks++; if (!got || cyc !== 39 || st !== 2'd0 || rd !== 32'h0000_0777)
            $display("FAIL recal_ok_rsp: got seen=%b cyc=%0d status=%0d rdata=%h want 1 39 0 00000777", got, cyc, st, rd); else n_pass++;
        n_checks++; if (last_wr_addr !== 11'h100 || last_wr_data !== 32'h0000_0002 || wr_count - wr0 !== 1 || rd_count - rd0 !== 2)
            $display("FAIL recal_ok_cal_write: got addr=%h wd=%h writes=%0d reads=%0d want 100 00000002 1 2",
                     last_wr_addr, last_wr_data, wr_count - wr0, rd_count - rd0); else n_pass++;
        step(1);
        n_checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1)
            $display("FAIL recal_ok_idle: got busy=%b ready=%b want 0 1", bus.busy, bus.cmd_ready); else n_pass++;
        clear_pll();
    endtask

    task automatic test_cal_timeout();
        bit got; int cyc; logic [31:0] rd; logic [1:0] st;
        int rd0 = rd_count;
        int wr0 = wr_count;
        user_reg = 32'h0BAD_F00D;
        cal_reg  = 32'h0000_0104;
        issue(11'h030, 32'h0, 32'h0, 1'b1, 100, got, cyc, rd, st);
        n_checks++; if (!got || cyc !== 54 || st !== 2'd1 || rd !== 32'h0BAD_F00D)
            $display("FAIL cal_timeout_rsp: got seen=%b cyc=%0d status=%0d rdata=%h want 1 54 1 0badf00d", got, cyc, st, rd); else n_pass++;
        step(5);
        n_checks++; if (last_wr_data !== 32'h0000_0106 || wr_count - wr0 !== 1 || rd_count - rd0 !== 2)
            $display("FAIL cal_timeout_xfers: got wd=%h writes=%0d reads=%0d want 00000106 1 2", last_wr_data, wr_count - wr0, rd_count - rd0); else n_pass++;
        cal_reg = 32'h0;
        clear_pll();
    endtask

    task automatic test_lock_timeout();
        bit got; int cyc; logic [31:0] rd; logic [1:0] st;
        sch_busy_on  = 1;
        sch_busy_off = 5;
        issue(11'h040, 32'h0, 32'h0, 1'b1, 100, got, cyc, rd, st);
        n_checks++; if (!got || cyc !== 58 || st !== 2'd2)
            $display("FAIL lock_timeout_rsp: got seen=%b cyc=%0d status=%0d want 1 58 2", got, cyc, st); else n_pass++;
        clear_pll();
        sch_busy_on  = 1;
        sch_busy_off = 5;
        sch_lock_on  = 55;
        issue(11'h040, 32'h0, 32'h0, 1'b1, 100, got, cyc, rd, st);
        n_checks++; if (!got || cyc !== 58 || st !== 2'd0)
            $display("FAIL lock_at_deadline_rsp: got seen=%b cyc=%0d status=%0d want 1 58 0", got, cyc, st); else n_pass++;
        clear_pll();
    endtask

    task automatic test_back_to_back();
        int rd0 = rd_count;
        int wr0 = wr_count;
        user_reg = 32'h1111_2222;
        bus.cmd_addr  = 11'h040;
        bus.cmd_mask  = 32'h0000_00FF;
        bus.cmd_data  = 32'h0000_00AB;
        bus.cmd_recal = 1'b0;
        bus.cmd_valid = 1'b1;
        step(1);
        bus.cmd_addr = 11'h050;
        bus.cmd_mask = 32'h0;
        step(2);
        n_checks++; if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.avmm_read !== 1'b0)
            $display("FAIL b2b_held_while_busy: got ready=%b rsp=%b rd=%b want 0 1 0", bus.cmd_ready, bus.rsp_valid, bus.avmm_read); else n_pass++;
        step(1);
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL b2b_ready_again: got %b want 1", bus.cmd_ready); else n_pass++;
        step(1);
        bus.cmd_valid = 1'b0;
        n_checks++; if (bus.avmm_read !== 1'b1 || bus.avmm_address !== 11'h050 || rd_count - rd0 !== 1)
            $display("FAIL b2b_second_read: got rd=%b addr=%h reads=%0d want 1 050 1", bus.avmm_read, bus.avmm_address, rd_count - rd0); else n_pass++;
        step(1);
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1111_2222)
            $display("FAIL b2b_second_rsp: got valid=%b rdata=%h want 1 11112222", bus.rsp_valid, bus.rsp_rdata); else n_pass++;
        step(1);
        n_checks++; if (wr_count - wr0 !== 1 || rd_count - rd0 !== 2 || last_wr_data !== 32'h1111_22AB)
            $display("FAIL b2b_xfers: got writes=%0d reads=%0d wd=%h want 1 2 111122ab", wr_count - wr0, rd_count - rd0, last_wr_data); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        bit got; int cyc; logic [31:0] rd; logic [1:0] st;
        int spurious = 0;
        int wr0 = wr_count;
        user_reg   = 32'h0;
        stall_wr_n = 1000;
        bus.cmd_addr  = 11'h060;
        bus.cmd_mask  = 32'h0000_000F;
        bus.cmd_data  = 32'h0000_0005;
        bus.cmd_recal = 1'b0;
        bus.cmd_valid = 1'b1;
        step(1);
        bus.cmd_valid = 1'b0;
        step(3);
        n_checks++; if (bus.avmm_write !== 1'b1) $display("FAIL rst_mid_write_stuck: got wr=%b want 1", bus.avmm_write); else n_pass++;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_checks++; if (bus.avmm_write !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL rst_mid_write_after: got wr=%b ready=%b rsp=%b busy=%b want 0 1 0 0",
                     bus.avmm_write, bus.cmd_ready, bus.rsp_valid, bus.busy); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            if (bus.rsp_valid !== 1'b0 || bus.avmm_write !== 1'b0) spurious++;
            step(1);
        end
        n_checks++; if (spurious !== 0 || wr_count - wr0 !== 0)
            $display("FAIL rst_mid_write_quiet: got spurious=%0d writes=%0d want 0 0", spurious, wr_count - wr0); else n_pass++;
        stall_wr_n = 0;
        user_reg   = 32'h0000_00F0;
        issue(11'h060, 32'h0000_000F, 32'h0000_0005, 1'b0, 20, got, cyc, rd, st);
        n_checks++; if (!got || cyc !== 3 || rd !== 32'h0000_00F0 || st !== 2'd0 || last_wr_data !== 32'h0000_00F5 || last_wr_addr !== 11'h060)
            $display("FAIL rst_next_cmd: got seen=%b cyc=%0d rdata=%h status=%0d wd=%h addr=%h want 1 3 000000f0 0 000000f5 060",
                     got, cyc, rd, st, last_wr_data, last_wr_addr); else n_pass++;
        step(2);
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid    = 1'b0;
        bus.cmd_addr     = '0;
        bus.cmd_mask     = '0;
        bus.cmd_data     = '0;
        bus.cmd_recal    = 1'b0;
        bus.pll_cal_busy = 1'b0;
        bus.pll_locked   = 1'b0;
        test_reset();
        test_rmw_latency();
        test_pure_read();
        test_waitrequest();
        test_recal_ok();
        test_cal_timeout();
        test_lock_timeout();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
